// File: rtl/tx_frame_fetch.sv
// Pulls length-prefixed frames of 16-bit words from the SRAM FIFO and streams them out as bytes.
// Optional build macro TX_FRAME_CRC16_EN appends a CRC-16/CCITT trailer after the payload.
module tx_frame_fetch #(
  parameter int MAX_LEN = 255,
  parameter int CNT_W   = 11
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic             sram_read,
  input  logic             sram_hint,
  input  logic             sram_empty,
  input  logic [CNT_W-1:0] sram_count,
  input  logic [15:0]      sram_data,
  output logic [7:0]       tx_byte,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_sof,
  output logic             tx_eof,
  output logic [10:0]      frame_len,
  output logic             busy,
  output logic             frame_err,
  output logic [3:0]       fsm_state
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] RD_HDR    = 4'd1;
  localparam logic [3:0] CHECK     = 4'd2;
  localparam logic [3:0] WAIT_BODY = 4'd3;
  localparam logic [3:0] RD_WORD   = 4'd4;
  localparam logic [3:0] EMIT_HI   = 4'd5;
  localparam logic [3:0] EMIT_LO   = 4'd6;
  localparam logic [3:0] DISCARD   = 4'd7;
  localparam logic [3:0] DONE      = 4'd8;
  localparam logic [3:0] CRC_HI    = 4'd9;
  localparam logic [3:0] CRC_LO    = 4'd10;

  localparam int CW = (CNT_W > 11) ? CNT_W : 11;

  logic [3:0]    state;
  logic [10:0]   len;
  logic [10:0]   wcnt;
  logic [10:0]   byte_idx;
  logic [7:0]    word_lo;
  logic [10:0]   last_idx;
  logic [CW-1:0] count_x;
  logic [CW-1:0] wcnt_x;
  logic [15:0]   crc;
  logic [15:0]   crc_upd;

`ifdef TX_FRAME_CRC16_EN
  localparam bit CRC_EN = 1'b1;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  // The sof byte restarts the CRC from its init value instead of the stale register.
  assign crc_upd = crc16_step(tx_sof ? 16'hFFFF : crc, tx_byte);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc <= '0;
    end else if (tx_ready && (state == EMIT_HI || state == EMIT_LO)) begin
      crc <= crc_upd;
    end
  end
`else
  localparam bit CRC_EN = 1'b0;
  assign crc     = '0;
  assign crc_upd = '0;
`endif

  assign last_idx  = len - 11'd1;
  assign count_x   = CW'(sram_count);
  assign wcnt_x    = CW'(wcnt);
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  // Handshakes: a word moves when sram_read && sram_hint in the same cycle (sram_read is held
  // until then, one request at a time); a byte moves when tx_valid && tx_ready, and
  // tx_byte/tx_sof/tx_eof stay frozen while tx_valid is high and tx_ready is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sram_read <= 1'b0;
      len       <= '0;
      wcnt      <= '0;
      byte_idx  <= '0;
      word_lo   <= '0;
      tx_valid  <= 1'b0;
      tx_byte   <= '0;
      tx_sof    <= 1'b0;
      tx_eof    <= 1'b0;
      frame_len <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && !sram_empty) state <= RD_HDR;
        end
        RD_HDR: begin
          if (!sram_read) begin
            sram_read <= 1'b1;
          end else if (sram_hint) begin
            sram_read <= 1'b0;
            len       <= sram_data[10:0];
            wcnt      <= 11'((12'(sram_data[10:0]) + 12'd1) >> 1);
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (len == '0) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (len > 11'(MAX_LEN)) begin
            frame_err <= 1'b1;
            state     <= DISCARD;
          end else begin
            frame_len <= len;
            byte_idx  <= '0;
            state     <= WAIT_BODY;
          end
        end
        WAIT_BODY: begin
          if (count_x >= wcnt_x) state <= RD_WORD;
        end
        RD_WORD: begin
          if (!sram_read) begin
            sram_read <= 1'b1;
          end else if (sram_hint) begin
            sram_read <= 1'b0;
            word_lo   <= sram_data[7:0];
            wcnt      <= wcnt - 11'd1;
            tx_valid  <= 1'b1;
            tx_byte   <= sram_data[15:8];
            tx_sof    <= (byte_idx == '0);
            tx_eof    <= !CRC_EN && (byte_idx == last_idx);
            state     <= EMIT_HI;
          end
        end
        EMIT_HI: begin
          if (tx_ready) begin
            byte_idx <= byte_idx + 11'd1;
            tx_sof   <= 1'b0;
            if (byte_idx == last_idx) begin
              tx_eof <= 1'b0;
              if (CRC_EN) begin
                tx_byte <= crc_upd[15:8];
                state   <= CRC_HI;
              end else begin
                tx_valid <= 1'b0;
                state    <= DONE;
              end
            end else begin
              tx_byte <= word_lo;
              tx_eof  <= !CRC_EN && (11'(byte_idx + 11'd1) == last_idx);
              state   <= EMIT_LO;
            end
          end
        end
        EMIT_LO: begin
          if (tx_ready) begin
            byte_idx <= byte_idx + 11'd1;
            tx_sof   <= 1'b0;
            tx_eof   <= 1'b0;
            if (wcnt != '0) begin
              tx_valid <= 1'b0;
              state    <= RD_WORD;
            end else if (CRC_EN) begin
              tx_byte <= crc_upd[15:8];
              state   <= CRC_HI;
            end else begin
              tx_valid <= 1'b0;
              state    <= DONE;
            end
          end
        end
        CRC_HI: begin
          if (tx_ready) begin
            tx_byte <= crc[7:0];
            tx_eof  <= 1'b1;
            state   <= CRC_LO;
          end
        end
        CRC_LO: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            tx_eof   <= 1'b0;
            state    <= DONE;
          end
        end
        DISCARD: begin
          if (wcnt == '0) begin
            state <= IDLE;
          end else if (!sram_read) begin
            if (count_x >= CW'(1)) sram_read <= 1'b1;
          end else if (sram_hint) begin
            sram_read <= 1'b0;
            wcnt      <= wcnt - 11'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_fetch.sv
// Self-checking bench for tx_frame_fetch: SRAM FIFO modelled as a word queue, expected byte
// stream built from the framing rules, random grant delays and consumer back-pressure.
module tb_tx_frame_fetch;

  localparam int MAX_LEN = 255;
  localparam int CNT_W   = 11;
`ifdef TX_FRAME_CRC16_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             sram_hint = 1'b0;
  logic             sram_empty = 1'b1;
  logic [CNT_W-1:0] sram_count = '0;
  logic [15:0]      sram_data = '0;
  logic             tx_ready = 1'b0;
  logic             sram_read;
  logic [7:0]       tx_byte;
  logic             tx_valid;
  logic             tx_sof;
  logic             tx_eof;
  logic [10:0]      frame_len;
  logic             busy;
  logic             frame_err;
  logic [3:0]       fsm_state;

  tx_frame_fetch #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .sram_read(sram_read), .sram_hint(sram_hint), .sram_empty(sram_empty),
    .sram_count(sram_count), .sram_data(sram_data),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_sof(tx_sof), .tx_eof(tx_eof), .frame_len(frame_len),
    .busy(busy), .frame_err(frame_err), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  int errors = 0;
  int checks = 0;

  logic [15:0] fifo_q[$];
  logic [20:0] exp_q[$];   // {frame_len, sof, eof, byte}
  logic [20:0] got_q[$];
  logic [7:0]  pay_q[$];

  int   hint_max = 0;
  int   ready_mode = 0;
  logic ready_fixed = 1'b1;
  int   wait_left = 0;
  bit   resp_hold = 0;

  // SRAM FIFO responder and consumer ready driver
  initial forever begin
    @(posedge clk); #2;
    if (sram_hint) begin
      void'(fifo_q.pop_front());
      sram_hint = 1'b0;
    end else if (sram_read && !resp_hold && fifo_q.size() > 0) begin
      if (wait_left == 0) begin
        sram_hint = 1'b1;
        wait_left = $urandom_range(0, hint_max);
      end else begin
        wait_left--;
      end
    end
    sram_count = CNT_W'(fifo_q.size());
    sram_empty = (fifo_q.size() == 0);
    sram_data  = (fifo_q.size() > 0) ? fifo_q[0] : 16'h0000;
    tx_ready   = (ready_mode != 0) ? ($urandom_range(0, 3) != 0) : ready_fixed;
  end

  // monitor
  logic       prev_stall = 1'b0, prev_sof = 1'b0, prev_eof = 1'b0;
  logic [7:0] prev_byte = '0;
  logic       prev_read = 1'b0, prev_hint = 1'b0, prev_err = 1'b0;
  int stall_viol = 0, read_viol = 0, err_pulses = 0, err_cycles = 0, valid_cycles = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (tx_valid) valid_cycles++;
      if (prev_stall && !(tx_valid && tx_byte == prev_byte && tx_sof == prev_sof && tx_eof == prev_eof))
        stall_viol++;
      if (tx_valid && tx_ready) got_q.push_back({frame_len, tx_sof, tx_eof, tx_byte});
      if (prev_read && !sram_read && !prev_hint) read_viol++;
      if (frame_err) err_cycles++;
      if (frame_err && !prev_err) err_pulses++;
    end
    prev_stall = reset_n && tx_valid && !tx_ready;
    prev_byte  = tx_byte;
    prev_sof   = tx_sof;
    prev_eof   = tx_eof;
    prev_read  = reset_n && sram_read;
    prev_hint  = sram_hint;
    prev_err   = reset_n && frame_err;
  end

  // reference model: header + packed words into the FIFO, expected bytes into exp_q
  task automatic load_frame(input logic [4:0] top, input logic [7:0] pad);
    int L;
    logic [15:0] crc;
    logic fb;
    L = pay_q.size();
    fifo_q.push_back({top, 11'(L)});
    for (int i = 0; i < L; i += 2)
      fifo_q.push_back({pay_q[i], (i + 1 < L) ? pay_q[i + 1] : pad});
    for (int i = 0; i < L; i++)
      exp_q.push_back({11'(L), 1'(i == 0), 1'(!CRC_ON && i == L - 1), pay_q[i]});
    if (CRC_ON) begin
      crc = 16'hFFFF;
      for (int i = 0; i < L; i++) begin
        for (int b = 7; b >= 0; b--) begin
          fb  = crc[15] ^ pay_q[i][b];
          crc = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
      end
      exp_q.push_back({11'(L), 1'b0, 1'b0, crc[15:8]});
      exp_q.push_back({11'(L), 1'b0, 1'b1, crc[7:0]});
    end
    pay_q.delete();
  endtask

  task automatic rand_payload(input int L);
    pay_q.delete();
    for (int i = 0; i < L; i++) pay_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic push_junk(input logic [15:0] hdr, input int n);
    fifo_q.push_back(hdr);
    for (int i = 0; i < n; i++) fifo_q.push_back(16'($urandom_range(0, 65535)));
  endtask

  task automatic wait_drain(input int budget, output int n);
    n = 0;
    while ((got_q.size() < exp_q.size() || busy || fifo_q.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  function automatic int first_mismatch(output logic [20:0] g, output logic [20:0] e);
    int n;
    n = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      e = (i < exp_q.size()) ? exp_q[i] : 'x;
      if (g !== e) return i;
    end
    g = '0;
    e = '0;
    return -1;
  endfunction

  task automatic clear_sb();
    got_q.delete();
    exp_q.delete();
    err_pulses = 0;
    err_cycles = 0;
    stall_viol = 0;
    read_viol  = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sram_read, tx_valid, tx_sof, tx_eof, frame_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000", {sram_read, tx_valid, tx_sof, tx_eof, frame_err});
    end
    checks++;
    if ({tx_byte, frame_len} !== 19'd0) begin
      errors++;
      $display("FAIL reset_data: tx_byte=%h frame_len=%0d required 0", tx_byte, frame_len);
    end
    checks++;
    if (busy !== 1'b0 || fsm_state !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b state=%0d required 0/0", busy, fsm_state);
    end
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || sram_read !== 1'b0) begin
      errors++;
      $display("FAIL idle_empty: busy=%b sram_read=%b required 0/0", busy, sram_read);
    end
  endtask

  task automatic test_basic();
    int n, mm;
    logic [20:0] g, e;
    clear_sb();
    pay_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    load_frame(5'd0, 8'hFF);
    wait_drain(1000, n);
    checks++;
    if (n >= 1000) begin errors++; $display("FAIL basic_timeout: waited %0d cycles", n); end
    mm = first_mismatch(g, e);
    checks++;
    if (mm >= 0) begin errors++; $display("FAIL basic_stream: index %0d got %h required %h", mm, g, e); end
    checks++;
    if (err_pulses != 0) begin errors++; $display("FAIL basic_err: frame_err pulses %0d required 0", err_pulses); end
  endtask

  task automatic test_odd();
    int n, mm;
    logic [20:0] g, e;
    clear_sb();
    pay_q = '{8'h11, 8'h22, 8'h33};
    load_frame(5'd0, 8'hFF);
    pay_q = '{8'h5A, 8'h6B};
    load_frame(5'd0, 8'h00);
    wait_drain(1000, n);
    checks++;
    if (n >= 1000) begin errors++; $display("FAIL odd_timeout: waited %0d cycles", n); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL odd_count: got %0d bytes required %0d", got_q.size(), exp_q.size());
    end
    mm = first_mismatch(g, e);
    checks++;
    if (mm >= 0) begin errors++; $display("FAIL odd_stream: index %0d got %h required %h", mm, g, e); end
  endtask

  task automatic test_enable();
    int n, mm;
    logic [20:0] g, e;
    clear_sb();
    enable = 1'b0;
    rand_payload(2);
    load_frame(5'd0, 8'h00);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || got_q.size() != 0 || fifo_q.size() != 2) begin
      errors++;
      $display("FAIL enable_low: busy=%b bytes=%0d fifo=%0d required 0/0/2", busy, got_q.size(), fifo_q.size());
    end
    enable = 1'b1;
    wait_drain(1000, n);
    mm = first_mismatch(g, e);
    checks++;
    if (n >= 1000 || mm >= 0) begin
      errors++;
      $display("FAIL enable_stream: cycles %0d index %0d got %h required %h", n, mm, g, e);
    end
  endtask

  task automatic test_wait_body();
    int n, mm;
    logic [20:0] g, e;
    logic [15:0] held;
    clear_sb();
    rand_payload(6);
    load_frame(5'd0, 8'h00);
    held = fifo_q.pop_back();
    valid_cycles = 0;
    repeat (50) @(posedge clk);
    #1;
    checks++;
    if (valid_cycles != 0) begin errors++; $display("FAIL wait_valid: tx_valid cycles %0d required 0", valid_cycles); end
    checks++;
    if (fsm_state !== 4'd3 || sram_read !== 1'b0) begin
      errors++;
      $display("FAIL wait_state: state=%0d sram_read=%b required 3/0", fsm_state, sram_read);
    end
    fifo_q.push_back(held);
    wait_drain(1000, n);
    mm = first_mismatch(g, e);
    checks++;
    if (n >= 1000 || mm >= 0) begin
      errors++;
      $display("FAIL wait_stream: cycles %0d index %0d got %h required %h", n, mm, g, e);
    end
  endtask

  task automatic test_bad_headers();
    int n, mm;
    logic [20:0] g, e;
    clear_sb();
    fifo_q.push_back(16'h0000);
    push_junk(16'h0101, 129);
    push_junk(16'h0100, 128);
    pay_q = '{8'hBE, 8'hEF};
    load_frame(5'h1F, 8'h00);
    wait_drain(5000, n);
    checks++;
    if (n >= 5000) begin errors++; $display("FAIL bad_timeout: waited %0d cycles, fifo left %0d", n, fifo_q.size()); end
    checks++;
    if (err_pulses != 3) begin errors++; $display("FAIL bad_pulses: frame_err pulses %0d required 3", err_pulses); end
    checks++;
    if (err_cycles != 3) begin errors++; $display("FAIL bad_width: frame_err high cycles %0d required 3", err_cycles); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bad_count: got %0d bytes required %0d", got_q.size(), exp_q.size());
    end
    mm = first_mismatch(g, e);
    checks++;
    if (mm >= 0) begin errors++; $display("FAIL bad_stream: index %0d got %h required %h", mm, g, e); end
  endtask

  task automatic test_random();
    int n, mm;
    logic [20:0] g, e;
    clear_sb();
    hint_max   = 7;
    ready_mode = 1;
    rand_payload(MAX_LEN);
    load_frame(5'($urandom_range(0, 31)), 8'h00);
    for (int f = 0; f < 4; f++) begin
      rand_payload($urandom_range(1, 40));
      load_frame(5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
    end
    wait_drain(20000, n);
    checks++;
    if (n >= 20000) begin errors++; $display("FAIL rand_timeout: waited %0d cycles", n); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d bytes required %0d", got_q.size(), exp_q.size());
    end
    mm = first_mismatch(g, e);
    checks++;
    if (mm >= 0) begin errors++; $display("FAIL rand_stream: index %0d got %h required %h", mm, g, e); end
    checks++;
    if (stall_viol != 0) begin errors++; $display("FAIL rand_stable: stall changes %0d required 0", stall_viol); end
    checks++;
    if (read_viol != 0) begin errors++; $display("FAIL rand_read: sram_read drops without grant %0d required 0", read_viol); end
    checks++;
    if (err_pulses != 0) begin errors++; $display("FAIL rand_err: frame_err pulses %0d required 0", err_pulses); end
    hint_max   = 0;
    ready_mode = 0;
  endtask

  task automatic test_reset_mid();
    int n, mm;
    bit found;
    logic [20:0] g, e;
    clear_sb();
    ready_fixed = 1'b1;
    rand_payload(8);
    load_frame(5'd0, 8'h00);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (fsm_state == 4'd6) found = 1;
    end
    ready_fixed = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (!found || fsm_state !== 4'd6) begin
      errors++;
      $display("FAIL mid_reach: state=%0d required 6 (EMIT_LO)", fsm_state);
    end
    resp_hold = 1;
    reset_n   = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({sram_read, tx_valid, tx_sof, tx_eof, frame_err, busy, tx_byte, frame_len} !== 25'd0) begin
      errors++;
      $display("FAIL mid_outputs: rd=%b v=%b sof=%b eof=%b err=%b busy=%b byte=%h len=%0d required all 0",
               sram_read, tx_valid, tx_sof, tx_eof, frame_err, busy, tx_byte, frame_len);
    end
    checks++;
    if (fsm_state !== 4'd0) begin errors++; $display("FAIL mid_state: state=%0d required 0", fsm_state); end
    checks++;
    if (fifo_q.size() != 3) begin errors++; $display("FAIL mid_fifo: words left %0d required 3", fifo_q.size()); end
    fifo_q.delete();
    @(posedge clk); #1;
    clear_sb();
    reset_n     = 1'b1;
    resp_hold   = 0;
    ready_fixed = 1'b1;
    rand_payload(3);
    load_frame(5'd0, 8'h00);
    wait_drain(1000, n);
    mm = first_mismatch(g, e);
    checks++;
    if (n >= 1000 || mm >= 0) begin
      errors++;
      $display("FAIL mid_recover: cycles %0d index %0d got %h required %h", n, mm, g, e);
    end
  endtask

`ifdef TX_FRAME_CRC16_EN
  task automatic test_crc();
    int n, mm;
    logic [20:0] g, e;
    clear_sb();
    pay_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    load_frame(5'd0, 8'h00);
    wait_drain(1000, n);
    mm = first_mismatch(g, e);
    checks++;
    if (n >= 1000 || mm >= 0) begin
      errors++;
      $display("FAIL crc_stream: cycles %0d index %0d got %h required %h", n, mm, g, e);
    end
    checks++;
    if (got_q.size() != 11 || got_q[9][7:0] !== 8'h29 || got_q[10][8:0] !== 9'h1B1) begin
      errors++;
      $display("FAIL crc_trailer: count %0d required 11, trailer must be 29 then B1 with eof", got_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_odd();
    test_enable();
    test_wait_body();
    test_bad_headers();
    test_random();
    test_reset_mid();
`ifdef TX_FRAME_CRC16_EN
    test_crc();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
